// File: rtl/uart_term_bridge.sv
// uart_term_bridge
// Bridges a byte stream from a UART receiver (AXI-Stream style) to a simple
// terminal controller command interface. Accepted bytes are buffered in a
// FIFO, then decoded one at a time:
//   - CLEAR_CHAR          -> one-cycle o_clearhome pulse
//   - printable 0x20..0x7E -> one-cycle o_putchar pulse with o_char = byte
//   - anything else        -> discarded, o_drop_cnt incremented (saturating)
// After every pulse the FSM spends one guard cycle, which lets the
// controller raise i_busy. It then waits for i_busy to drop before it
// issues the next command.
//
// Ports
//   i_clk          system clock
//   i_rst_n        synchronous active-low reset
//   s_axis_tdata   received byte
//   s_axis_tvalid  received byte valid
//   s_axis_tready  bridge can accept a byte (FIFO not full)
//   i_busy         terminal controller is executing a command
//   o_putchar      one-cycle pulse: draw o_char
//   o_clearhome    one-cycle pulse: clear screen and home cursor
//   o_char         character for putchar, held until the next putchar
//   o_level        FIFO occupancy
//   o_drop_cnt     saturating count of discarded bytes
module uart_term_bridge #(
  parameter int unsigned DEPTH      = 16,
  parameter logic [7:0]  CLEAR_CHAR = 8'h0C
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [7:0]               s_axis_tdata,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  input  logic                     i_busy,
  output logic                     o_putchar,
  output logic                     o_clearhome,
  output logic [7:0]               o_char,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic [7:0]               o_drop_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);
  localparam logic [LW-1:0] LEVEL_ONE  = LW'(1);
  localparam logic [LW-1:0] LEVEL_ZERO = LW'(0);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);
  localparam logic [AW-1:0] PTR_ZERO   = AW'(0);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PULSE = 2'd1;
  localparam logic [1:0] GUARD = 2'd2;
  localparam logic [1:0] WAIT  = 2'd3;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          tready_q, tready_d;

  logic [1:0]    state_q, state_d;
  logic          cmd_clear_q, cmd_clear_d;
  logic [7:0]    cmd_char_q, cmd_char_d;
  logic          putchar_q, putchar_d;
  logic          clearhome_q, clearhome_d;
  logic [7:0]    char_q, char_d;
  logic [7:0]    drop_q, drop_d;

  logic          push_s;
  logic          pop_s;
  logic [7:0]    head_s;
  logic          is_print_s;

  // FIFO handshake: push on accepted beat, pop only from IDLE when the
  // controller is free and there is something to pop.
  always_comb begin
    push_s     = s_axis_tvalid & tready_q;
    pop_s      = (state_q == IDLE) && (level_q != LEVEL_ZERO) && !i_busy;
    head_s     = mem_q[rd_ptr_q];
    is_print_s = (head_s >= 8'h20) && (head_s <= 8'h7E);
  end

  // FIFO pointer and occupancy next state; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   level_d = level_q + LEVEL_ONE;
      2'b01:   level_d = level_q - LEVEL_ONE;
      default: level_d = level_q;
    endcase
    // tready is registered from the next level so it reads 0 throughout reset.
    tready_d = (level_d < FULL_LEVEL);
  end

  // Command FSM: decode popped byte, emit one registered pulse, guard, wait.
  always_comb begin
    state_d     = state_q;
    cmd_clear_d = cmd_clear_q;
    cmd_char_d  = cmd_char_q;
    putchar_d   = 1'b0;
    clearhome_d = 1'b0;
    char_d      = char_q;
    drop_d      = drop_q;
    case (state_q)
      IDLE: begin
        if (pop_s) begin
          // The clear code takes priority even if it falls in the printable range.
          if (head_s == CLEAR_CHAR) begin
            cmd_clear_d = 1'b1;
            state_d     = PULSE;
          end else if (is_print_s) begin
            cmd_clear_d = 1'b0;
            cmd_char_d  = head_s;
            state_d     = PULSE;
          end else begin
            if (drop_q != 8'hFF) begin
              drop_d = drop_q + 8'd1;
            end else begin
              drop_d = drop_q;
            end
            state_d = IDLE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      PULSE: begin
        // The pulse registers load here, so the pulse is visible while in GUARD.
        if (cmd_clear_q) begin
          clearhome_d = 1'b1;
        end else begin
          putchar_d = 1'b1;
          char_d    = cmd_char_q;
        end
        state_d = GUARD;
      end
      GUARD: begin
        // Gives the controller a cycle to raise i_busy before WAIT samples it.
        state_d = WAIT;
      end
      WAIT: begin
        if (!i_busy) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr_q    <= PTR_ZERO;
      rd_ptr_q    <= PTR_ZERO;
      level_q     <= LEVEL_ZERO;
      tready_q    <= 1'b0;
      state_q     <= IDLE;
      cmd_clear_q <= 1'b0;
      cmd_char_q  <= 8'h00;
      putchar_q   <= 1'b0;
      clearhome_q <= 1'b0;
      char_q      <= 8'h00;
      drop_q      <= 8'h00;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      tready_q    <= tready_d;
      state_q     <= state_d;
      cmd_clear_q <= cmd_clear_d;
      cmd_char_q  <= cmd_char_d;
      putchar_q   <= putchar_d;
      clearhome_q <= clearhome_d;
      char_q      <= char_d;
      drop_q      <= drop_d;
    end
  end

  // FIFO storage; contents need no reset because the pointers gate every read.
  always_ff @(posedge i_clk) begin
    if (push_s && i_rst_n) begin
      mem_q[wr_ptr_q] <= s_axis_tdata;
    end
  end

  assign s_axis_tready = tready_q;
  assign o_putchar     = putchar_q;
  assign o_clearhome   = clearhome_q;
  assign o_char        = char_q;
  assign o_level       = level_q;
  assign o_drop_cnt    = drop_q;

endmodule

// File: tb/tb_uart_term_bridge.sv
// Self-checking bench for uart_term_bridge (DEPTH = 16, CLEAR_CHAR = 8'h0C).
module tb_uart_term_bridge;

  localparam int NRAND = 4000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] s_axis_tdata = 8'h00;
  logic       s_axis_tvalid = 1'b0;
  logic       s_axis_tready;
  logic       i_busy = 1'b0;
  logic       o_putchar;
  logic       o_clearhome;
  logic [7:0] o_char;
  logic [4:0] o_level;
  logic [7:0] o_drop_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_pulse = -1;
  int obs[$];
  int pcyc[$];
  bit done = 1'b0;

  typedef struct {
    logic [7:0] data;
    int         kind;   // 0 drop, 1 putchar, 2 clearhome
  } vec_t;

  uart_term_bridge #(.DEPTH(16), .CLEAR_CHAR(8'h0C)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .i_busy       (i_busy),
    .o_putchar    (o_putchar),
    .o_clearhome  (o_clearhome),
    .o_char       (o_char),
    .o_level      (o_level),
    .o_drop_cnt   (o_drop_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor: records every command (clearhome as 256) and its cycle.
  always @(negedge clk) begin
    if (o_putchar === 1'b1 && o_clearhome === 1'b1) begin
      checks++;
      errors++;
      $display("FAIL pulse_exclusive: both pulses high at cycle %0d", cyc);
    end
    if (o_putchar === 1'b1 || o_clearhome === 1'b1) begin
      if (last_pulse >= 0) begin
        checks++;
        if (cyc - last_pulse < 3) begin
          errors++;
          $display("FAIL pulse_spacing: got %0d cycles, required >= 3", cyc - last_pulse);
        end
      end
      last_pulse = cyc;
      obs.push_back(o_clearhome ? 256 : int'(o_char));
      pcyc.push_back(cyc);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic check_ge(input string name, input int act, input int lim);
    checks++;
    if (act < lim) begin
      errors++;
      $display("FAIL %s: got %0d, required >= %0d", name, act, lim);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, output int acc);
    int n;
    n = 0;
    s_axis_tdata  = b;
    s_axis_tvalid = 1'b1;
    while (s_axis_tready !== 1'b1 && n < 300) begin
      tick(1);
      n++;
    end
    if (s_axis_tready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: byte %0h not accepted, required acceptance", b);
      acc = -1;
    end else begin
      tick(1);
      acc = cyc;
    end
    s_axis_tvalid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    s_axis_tvalid = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  // Controller model: holds i_busy for 10 cycles after each pulse.
  task automatic ctrl_run(input int n);
    int bc;
    bc = 0;
    repeat (n) begin
      @(negedge clk);
      if (o_putchar === 1'b1 || o_clearhome === 1'b1) bc = 10;
      if (bc > 0) begin
        i_busy = 1'b1;
        bc--;
      end else begin
        i_busy = 1'b0;
      end
    end
  endtask

  initial begin
    vec_t vecs[12];
    int base, k, k2, d0, act, expv, n, mism, first_bad;
    int exp_q[$];

    vecs[0]  = '{8'h41, 1};
    vecs[1]  = '{8'h20, 1};
    vecs[2]  = '{8'h7E, 1};
    vecs[3]  = '{8'h7F, 0};
    vecs[4]  = '{8'h1F, 0};
    vecs[5]  = '{8'h0C, 2};
    vecs[6]  = '{8'h0A, 0};
    vecs[7]  = '{8'h80, 0};
    vecs[8]  = '{8'hFF, 0};
    vecs[9]  = '{8'h5A, 1};
    vecs[10] = '{8'h00, 0};
    vecs[11] = '{8'h21, 1};

    // Reset values, sampled while reset is held.
    tick(3);
    check("rst_tready", int'(s_axis_tready), 0);
    check("rst_level", int'(o_level), 0);
    check("rst_putchar", int'(o_putchar), 0);
    check("rst_clearhome", int'(o_clearhome), 0);
    check("rst_char", int'(o_char), 0);
    check("rst_drop", int'(o_drop_cnt), 0);
    rst_n = 1'b1;
    tick(1);
    check("rst_release_tready", int'(s_axis_tready), 1);

    // Single putchar: latency and pulse width.
    base = obs.size();
    send_byte(8'h41, k);
    tick(6);
    check("lat_pulse_count", obs.size() - base, 1);
    act = (obs.size() > base) ? obs[base] : -1;
    check("lat_char", act, 8'h41);
    act = (pcyc.size() > base) ? pcyc[base] - k : -1;
    check("lat_cycles", act, 2);
    check("lat_ochar_hold", int'(o_char), 8'h41);
    check("lat_level", int'(o_level), 0);

    // Decode table.
    for (int i = 0; i < 12; i++) begin
      base = obs.size();
      d0 = int'(o_drop_cnt);
      send_byte(vecs[i].data, k);
      tick(6);
      expv = (vecs[i].kind == 0) ? 0 : 1;
      check($sformatf("vec%0d_count", i), obs.size() - base, expv);
      if (vecs[i].kind == 0) begin
        check($sformatf("vec%0d_drop", i), int'(o_drop_cnt), d0 + 1);
      end else begin
        act = (obs.size() > base) ? obs[base] : -1;
        expv = (vecs[i].kind == 2) ? 256 : int'(vecs[i].data);
        check($sformatf("vec%0d_value", i), act, expv);
      end
    end

    // Clearhome then putchar with a busy controller.
    do_reset();
    base = obs.size();
    send_byte(8'h0C, k);
    send_byte(8'h42, k2);
    ctrl_run(40);
    i_busy = 1'b0;
    tick(2);
    check("busy_count", obs.size() - base, 2);
    if (obs.size() - base == 2) begin
      check("busy_first_clear", obs[base], 256);
      check("busy_second_char", obs[base + 1], 8'h42);
      check_ge("busy_gap", pcyc[base + 1] - pcyc[base], 12);
    end

    // Fill to full while busy, then drain.
    do_reset();
    i_busy = 1'b1;
    base = obs.size();
    for (int i = 0; i < 16; i++) send_byte(8'h50 + 8'(i), k);
    s_axis_tdata  = 8'h70;
    s_axis_tvalid = 1'b1;
    tick(2);
    check("full_level", int'(o_level), 16);
    check("full_tready", int'(s_axis_tready), 0);
    check("full_no_pulse", obs.size() - base, 0);
    i_busy = 1'b0;
    send_byte(8'h70, k);
    n = 0;
    while (obs.size() - base < 17 && n < 200) begin
      tick(1);
      n++;
    end
    check("full_drain_count", obs.size() - base, 17);
    mism = 0;
    for (int i = 0; i < 17; i++) begin
      expv = (i < 16) ? 8'h50 + i : 8'h70;
      if (obs.size() > base + i && obs[base + i] != expv) mism++;
    end
    check("full_drain_order_mismatches", mism, 0);
    check("full_drain_level", int'(o_level), 0);

    // Drop counter saturation.
    do_reset();
    base = obs.size();
    send_byte(8'h0A, k);
    send_byte(8'h7F, k);
    send_byte(8'h80, k);
    tick(3);
    check("drop_three", int'(o_drop_cnt), 3);
    for (int i = 0; i < 300; i++) send_byte(8'h01, k);
    tick(5);
    check("drop_saturated", int'(o_drop_cnt), 255);
    check("drop_no_pulse", obs.size() - base, 0);

    // Reset during WAIT with bytes queued.
    do_reset();
    send_byte(8'h41, k);
    tick(1);
    i_busy = 1'b1;
    for (int i = 0; i < 5; i++) send_byte(8'h61 + 8'(i), k);
    tick(2);
    check("wait_queued_level", int'(o_level), 5);
    base = obs.size();
    rst_n = 1'b0;
    tick(2);
    check("wait_rst_level", int'(o_level), 0);
    check("wait_rst_tready", int'(s_axis_tready), 0);
    rst_n = 1'b1;
    tick(1);
    check("wait_post_tready", int'(s_axis_tready), 1);
    tick(5);
    check("wait_post_no_pulse", obs.size() - base, 0);
    send_byte(8'h55, k);
    tick(5);
    check("wait_busy_hold", obs.size() - base, 0);
    check("wait_busy_level", int'(o_level), 1);
    i_busy = 1'b0;
    tick(6);
    check("wait_release_count", obs.size() - base, 1);
    act = (obs.size() > base) ? obs[base] : -1;
    check("wait_release_char", act, 8'h55);

    // Random tvalid gaps and random i_busy against a scoreboard.
    do_reset();
    base = obs.size();
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < NRAND; i++) begin
          int r;
          logic [7:0] b;
          r = int'($urandom_range(0, 15));
          if (r == 0) b = 8'h0C;
          else if (r == 1) b = 8'($urandom_range(0, 31));
          else if (r == 2) b = 8'($urandom_range(127, 255));
          else b = 8'($urandom_range(32, 126));
          if (b == 8'h0C) exp_q.push_back(256);
          else if (b >= 8'h20 && b <= 8'h7E) exp_q.push_back(int'(b));
          send_byte(b, k);
          tick(int'($urandom_range(0, 2)));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(negedge clk);
          i_busy = ($urandom_range(0, 3) == 0);
        end
        i_busy = 1'b0;
      end
    join
    n = 0;
    while (obs.size() - base < exp_q.size() && n < 3000) begin
      tick(1);
      n++;
    end
    tick(8);
    check("rand_count", obs.size() - base, exp_q.size());
    mism = 0;
    first_bad = -1;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (obs.size() > base + i && obs[base + i] != exp_q[i]) begin
        mism++;
        if (first_bad < 0) first_bad = i;
      end
    end
    if (mism != 0) $display("first scoreboard difference at index %0d", first_bad);
    check("rand_mismatches", mism, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
